// File: rtl/i_cache_if.sv
`default_nettype none
// ============================================================================
// i_cache_if : fetch-side and refill-side signals of the instruction cache
// Revision   : 1.0
// ============================================================================
interface i_cache_if #(
  parameter int LINE_W = 256
);
  logic              cpu_icache_en;
  logic [31:0]       virtual_addr;
  logic [31:0]       physical_addr;
  logic              icache_free;
  logic              icache_hit;
  logic [31:0]       icache_cpu_data;
  logic              icache_cpu_data_en;
  logic              mem_icache_return_en;
  logic [LINE_W-1:0] mem_icache_return_data;
  logic              cache_mem_read_en;
  logic [31:0]       cache_mem_read_addr;

  modport master (
    output cpu_icache_en, virtual_addr, physical_addr,
    output mem_icache_return_en, mem_icache_return_data,
    input  icache_free, icache_hit, icache_cpu_data, icache_cpu_data_en,
    input  cache_mem_read_en, cache_mem_read_addr
  );

  modport slave (
    input  cpu_icache_en, virtual_addr, physical_addr,
    input  mem_icache_return_en, mem_icache_return_data,
    output icache_free, icache_hit, icache_cpu_data, icache_cpu_data_en,
    output cache_mem_read_en, cache_mem_read_addr
  );
endinterface
`default_nettype wire

// File: rtl/i_cache.sv
`default_nettype none
// ============================================================================
// i_cache  : 2-way set-associative VIPT instruction cache, 128 x 32-byte lines
// Revision : 1.0
// ============================================================================
module i_cache #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5,
  parameter int BANK_NUM = 8
) (
  input  wire logic clk,
  input  wire logic reset,
  i_cache_if.slave  bus
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = BANK_NUM * 32;
  localparam int WSEL_W = $clog2(BANK_NUM);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MISS   = 2'd2,
    S_REFILL = 2'd3
  } state_t;

  state_t                r_state;
  logic [SETS-1:0]       r_valid0;
  logic [SETS-1:0]       r_valid1;
  logic [SETS-1:0]       r_lru;
  logic [TAG_W-1:0]      r_tag0  [SETS];
  logic [TAG_W-1:0]      r_tag1  [SETS];
  logic [LINE_W-1:0]     r_data0 [SETS];
  logic [LINE_W-1:0]     r_data1 [SETS];

  logic [INDEX_W-1:0]    r_idx;
  logic [WSEL_W-1:0]     r_wsel;
  logic [31:OFFSET_W]    r_line;
  logic [31:0]           r_fill_word;

  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit0;
  logic                  w_hit1;
  logic [31:0]           w_word0;
  logic [31:0]           w_word1;
  logic [31:0]           w_ret_word;
  logic                  w_fill;
  logic                  w_unused_bits;

  assign w_tag      = r_line[31:32-TAG_W];
  assign w_hit0     = r_valid0[r_idx] && (r_tag0[r_idx] == w_tag);
  assign w_hit1     = r_valid1[r_idx] && (r_tag1[r_idx] == w_tag);
  assign w_word0    = r_data0[r_idx][{r_wsel, 5'd0} +: 32];
  assign w_word1    = r_data1[r_idx][{r_wsel, 5'd0} +: 32];
  assign w_ret_word = bus.mem_icache_return_data[{r_wsel, 5'd0} +: 32];
  assign w_fill     = (r_state == S_MISS) && bus.mem_icache_return_en;

  // Address bits that neither index, select nor tag the line.
  assign w_unused_bits = ^{bus.virtual_addr[31:OFFSET_W+INDEX_W],
                           bus.virtual_addr[1:0],
                           bus.physical_addr[OFFSET_W-1:0]};

  // Tag/data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (r_lru[r_idx]) begin
        r_tag1[r_idx]  <= w_tag;
        r_data1[r_idx] <= bus.mem_icache_return_data;
      end else begin
        r_tag0[r_idx]  <= w_tag;
        r_data0[r_idx] <= bus.mem_icache_return_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state                 <= S_IDLE;
      r_valid0                <= '0;
      r_valid1                <= '0;
      r_lru                   <= '0;
      r_idx                   <= '0;
      r_wsel                  <= '0;
      r_line                  <= '0;
      r_fill_word             <= '0;
      bus.icache_free         <= 1'b1;
      bus.icache_hit          <= 1'b0;
      bus.icache_cpu_data     <= '0;
      bus.icache_cpu_data_en  <= 1'b0;
      bus.cache_mem_read_en   <= 1'b0;
      bus.cache_mem_read_addr <= '0;
    end else begin
      bus.icache_hit         <= 1'b0;
      bus.icache_cpu_data    <= '0;
      bus.icache_cpu_data_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_icache_en) begin
            r_idx           <= bus.virtual_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
            r_wsel          <= bus.virtual_addr[OFFSET_W-1:2];
            r_line          <= bus.physical_addr[31:OFFSET_W];
            bus.icache_free <= 1'b0;
            r_state         <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit0 || w_hit1) begin
            bus.icache_hit         <= 1'b1;
            bus.icache_cpu_data_en <= 1'b1;
            bus.icache_cpu_data    <= w_hit0 ? w_word0 : w_word1;
            // Way 0 wins a double hit, so the other way becomes LRU.
            r_lru[r_idx]           <= w_hit0;
            bus.icache_free        <= 1'b1;
            r_state                <= S_IDLE;
          end else begin
            bus.cache_mem_read_en   <= 1'b1;
            bus.cache_mem_read_addr <= {r_line, {OFFSET_W{1'b0}}};
            r_state                 <= S_MISS;
          end
        end
        S_MISS: begin
          if (bus.mem_icache_return_en) begin
            if (r_lru[r_idx]) r_valid1[r_idx] <= 1'b1;
            else              r_valid0[r_idx] <= 1'b1;
            r_lru[r_idx]            <= ~r_lru[r_idx];
            r_fill_word             <= w_ret_word;
            bus.cache_mem_read_en   <= 1'b0;
            bus.cache_mem_read_addr <= '0;
            r_state                 <= S_REFILL;
          end
        end
        S_REFILL: begin
          bus.icache_cpu_data_en <= 1'b1;
          bus.icache_cpu_data    <= r_fill_word;
          bus.icache_free        <= 1'b1;
          r_state                <= S_IDLE;
        end
        default: begin
          bus.icache_free <= 1'b1;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_i_cache.sv
`default_nettype none
// ============================================================================
// tb_i_cache : directed checks of hit, miss, LRU eviction, stalls and reset
// Revision   : 1.0
// ============================================================================
module tb_i_cache;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  i_cache_if bus ();

  i_cache dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] pa);
    bus.cpu_icache_en = 1'b1;
    bus.virtual_addr  = va;
    bus.physical_addr = pa;
    step();
    bus.cpu_icache_en = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] va, input logic [31:0] pa,
                            input logic [31:0] exp);
    issue(va, pa);
    check({tag, "_lookup_free"}, {31'd0, bus.icache_free}, 32'd0);
    step();
    check({tag, "_read_en"}, {31'd0, bus.cache_mem_read_en}, 32'd0);
    check({tag, "_data_en"}, {31'd0, bus.icache_cpu_data_en}, 32'd1);
    check({tag, "_hit"},     {31'd0, bus.icache_hit}, 32'd1);
    check({tag, "_data"},    bus.icache_cpu_data, exp);
  endtask

  task automatic expect_miss(input string tag, input logic [31:0] va, input logic [31:0] pa,
                             input logic [255:0] line, input int delay, input logic [31:0] exp);
    logic [31:0] addr;
    addr = {pa[31:5], 5'd0};
    issue(va, pa);
    step();
    check({tag, "_read_en"},   {31'd0, bus.cache_mem_read_en}, 32'd1);
    check({tag, "_read_addr"}, bus.cache_mem_read_addr, addr);
    check({tag, "_no_data"},   {31'd0, bus.icache_cpu_data_en}, 32'd0);
    for (int d = 0; d < delay; d++) begin
      step();
      check({tag, "_hold_en"},   {31'd0, bus.cache_mem_read_en}, 32'd1);
      check({tag, "_hold_addr"}, bus.cache_mem_read_addr, addr);
    end
    bus.mem_icache_return_en   = 1'b1;
    bus.mem_icache_return_data = line;
    step();
    bus.mem_icache_return_en   = 1'b0;
    bus.mem_icache_return_data = '0;
    check({tag, "_read_fall"},   {31'd0, bus.cache_mem_read_en}, 32'd0);
    check({tag, "_refill_wait"}, {31'd0, bus.icache_cpu_data_en}, 32'd0);
    step();
    check({tag, "_data_en"}, {31'd0, bus.icache_cpu_data_en}, 32'd1);
    check({tag, "_hit"},     {31'd0, bus.icache_hit}, 32'd0);
    check({tag, "_data"},    bus.icache_cpu_data, exp);
  endtask

  initial begin
    bus.cpu_icache_en          = 1'b0;
    bus.virtual_addr           = '0;
    bus.physical_addr          = '0;
    bus.mem_icache_return_en   = 1'b0;
    bus.mem_icache_return_data = '0;
    reset = 1'b0;
    step();
    step();
    check("rst_free",    {31'd0, bus.icache_free}, 32'd1);
    check("rst_read_en", {31'd0, bus.cache_mem_read_en}, 32'd0);
    check("rst_data_en", {31'd0, bus.icache_cpu_data_en}, 32'd0);
    reset = 1'b1;
    step();
    check("idle_free", {31'd0, bus.icache_free}, 32'd1);
    check("idle_data", bus.icache_cpu_data, 32'd0);

    expect_miss("cold", 32'h4, 32'h40, mk_line(32'h1234_5677), 0, 32'h1234_5678);
    expect_hit("rehit", 32'h4, 32'h40, 32'h1234_5678);
    expect_hit("word7", 32'h1C, 32'h5C, 32'h1234_567E);

    expect_miss("tag1", 32'h4, 32'h1040, mk_line(32'hA000_0000), 0, 32'hA000_0001);
    expect_miss("tag2_slow", 32'h4, 32'h2040, mk_line(32'hB000_0000), 5, 32'hB000_0001);
    expect_hit("tag2_hit", 32'h4, 32'h2040, 32'hB000_0001);

    // Stray refill pulse while idle must leave everything untouched.
    bus.mem_icache_return_en   = 1'b1;
    bus.mem_icache_return_data = mk_line(32'hDEAD_0000);
    step();
    bus.mem_icache_return_en   = 1'b0;
    bus.mem_icache_return_data = '0;
    check("stray_data_en", {31'd0, bus.icache_cpu_data_en}, 32'd0);
    check("stray_read_en", {31'd0, bus.cache_mem_read_en}, 32'd0);
    check("stray_free",    {31'd0, bus.icache_free}, 32'd1);
    expect_hit("stray_after", 32'h4, 32'h2040, 32'hB000_0001);

    expect_miss("evicted", 32'h4, 32'h40, mk_line(32'h1234_5677), 0, 32'h1234_5678);
    expect_hit("kept_tag2", 32'h4, 32'h2040, 32'hB000_0001);
    expect_miss("tag1_gone", 32'h4, 32'h1040, mk_line(32'hC000_0000), 0, 32'hC000_0001);

    expect_miss("top_set", 32'hFE4, 32'hFFFF_F020, mk_line(32'h5555_0000), 1, 32'h5555_0001);
    expect_hit("top_hit", 32'hFE4, 32'hFFFF_F020, 32'h5555_0001);

    // Reset while waiting for a refill.
    issue(32'h4, 32'h3040);
    step();
    check("mrst_pre_read_en", {31'd0, bus.cache_mem_read_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("mrst_read_en", {31'd0, bus.cache_mem_read_en}, 32'd0);
    check("mrst_free",    {31'd0, bus.icache_free}, 32'd1);
    check("mrst_addr",    bus.cache_mem_read_addr, 32'd0);
    step();
    reset = 1'b1;
    step();
    bus.mem_icache_return_en   = 1'b1;
    bus.mem_icache_return_data = mk_line(32'hEEEE_0000);
    step();
    bus.mem_icache_return_en   = 1'b0;
    bus.mem_icache_return_data = '0;
    check("late_ret_data_en", {31'd0, bus.icache_cpu_data_en}, 32'd0);
    check("late_ret_free",    {31'd0, bus.icache_free}, 32'd1);
    expect_miss("replay", 32'h4, 32'h40, mk_line(32'h1234_5677), 0, 32'h1234_5678);
    expect_miss("replay_top", 32'hFE4, 32'hFFFF_F020, mk_line(32'h6666_0000), 0, 32'h6666_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
